// File: rtl/vec_pkg.sv
// Shared vector writeback definitions: SEW codes, default width and element/byte mask helpers.
package vec_pkg;

  localparam int unsigned DataWDefault = 256;

  localparam logic [2:0] VsewE8  = 3'd0;
  localparam logic [2:0] VsewE16 = 3'd1;
  localparam logic [2:0] VsewE32 = 3'd2;
  localparam logic [2:0] VsewE64 = 3'd3;

  // Elements per 256-bit register; 0 flags an illegal encoding.
  function automatic logic [5:0] vlmax(input logic [2:0] vsew);
    logic [5:0] n;
    case (vsew)
      VsewE8:  n = 6'd32;
      VsewE16: n = 6'd16;
      VsewE32: n = 6'd8;
      VsewE64: n = 6'd4;
      default: n = 6'd0;
    endcase
    return n;
  endfunction

  function automatic logic [31:0] elem_to_byte_en(input logic [31:0] elem_en,
                                                  input logic [2:0]  vsew);
    logic [31:0] be;
    for (int unsigned b = 0; b < 32; b++) begin
      be[b] = elem_en[b >> vsew[1:0]];
    end
    return be;
  endfunction

endpackage

// File: rtl/vec_writeback_if.sv
// VRF read/write port bundle between the writeback stage (master) and the register file (slave).
interface vec_writeback_if #(
  parameter int unsigned DATA_W     = 256,
  parameter int unsigned REG_ADDR_W = 5
);
  logic                  vrf_rd_en;
  logic [REG_ADDR_W-1:0] vrf_rd_addr;
  logic [DATA_W-1:0]     vrf_rd_data;
  logic                  vrf_we;
  logic [REG_ADDR_W-1:0] vrf_wr_addr;
  logic [DATA_W-1:0]     vrf_wr_data;
  logic                  vrf_wr_ready;

  modport master (
    output vrf_rd_en, vrf_rd_addr, vrf_we, vrf_wr_addr, vrf_wr_data,
    input  vrf_rd_data, vrf_wr_ready
  );

  modport slave (
    input  vrf_rd_en, vrf_rd_addr, vrf_we, vrf_wr_addr, vrf_wr_data,
    output vrf_rd_data, vrf_wr_ready
  );
endinterface

// File: rtl/vec_wb_fifo.sv
// Synchronous result FIFO for the writeback stage; rst_ni is a synchronous active-low reset.
module vec_wb_fifo #(
  parameter int unsigned Width = 1,
  parameter int unsigned Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [PtrW:0]    cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (pop_i) rptr_q <= rptr_q + 1'b1;
      if (push_i && !pop_i)      cnt_q <= cnt_q + 1'b1;
      else if (!push_i && pop_i) cnt_q <= cnt_q - 1'b1;
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign full_o  = (cnt_q == Depth[PtrW:0]);
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/vec_writeback.sv
// Vector writeback: buffers execute results, merges active elements over old vd, writes the VRF.
// Define VEC_WB_AGNOSTIC_EN for the agnostic policy (inactive/tail = all ones, no old-vd read).
module vec_writeback #(
  parameter int unsigned DATA_W     = vec_pkg::DataWDefault,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  vec_op_done,
  input  logic [DATA_W-1:0]     vec_exec_out,
  input  logic [REG_ADDR_W-1:0] vd_addr,
  input  logic [2:0]            vsew,
  input  logic [31:0]           vlen,
  input  logic                  vm,
  input  logic [31:0]           v0_mask,
  vec_writeback_if.master       vrf,
  output logic                  wb_ready,
  output logic                  wb_done,
  output logic                  err_overflow,
  output logic                  err_illegal
);
  import vec_pkg::*;

  localparam int unsigned EntryW   = DATA_W + REG_ADDR_W + 3 + 32 + 1 + 32;
  localparam int unsigned NumBytes = DATA_W / 8;

  typedef enum logic [1:0] {StIdle, StCheck, StMerge, StWrite} state_e;

  logic              fifo_full, fifo_empty, push, pop;
  logic [EntryW-1:0] head;

  logic [DATA_W-1:0]     h_data;
  logic [REG_ADDR_W-1:0] h_vd;
  logic [2:0]            h_vsew;
  logic [31:0]           h_vl, h_v0;
  logic                  h_vm;

  logic [5:0]  h_vlmax, h_eff_vl;
  logic [31:0] h_elem_en;
  logic        h_illegal;

  state_e                state_q;
  logic [DATA_W-1:0]     data_q, wr_data_q, fill, merged;
  logic [REG_ADDR_W-1:0] vd_q, rd_addr_q;
  logic [31:0]           be_q;
  logic                  illegal_q, zero_q, rd_en_q, we_q, done_q, ovf_q, ill_pulse_q;

  assign pop  = (state_q == StIdle) && !fifo_empty;
  assign push = vec_op_done && (!fifo_full || pop);

  vec_wb_fifo #(
    .Width (EntryW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({vec_exec_out, vd_addr, vsew, vlen, vm, v0_mask}),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign {h_data, h_vd, h_vsew, h_vl, h_vm, h_v0} = head;

  // Element enables are resolved while the entry is still at the FIFO head.
  always_comb begin
    h_vlmax   = vlmax(h_vsew);
    h_illegal = (h_vlmax == 6'd0);
    h_eff_vl  = (h_vl > 32'(h_vlmax)) ? h_vlmax : h_vl[5:0];
    for (int unsigned i = 0; i < 32; i++) begin
      h_elem_en[i] = (i < 32'(h_eff_vl)) && (h_vm || h_v0[i]);
    end
  end

`ifdef VEC_WB_AGNOSTIC_EN
  logic unused_rd_data;
  assign unused_rd_data = ^vrf.vrf_rd_data;
  assign fill = '1;
`else
  assign fill = vrf.vrf_rd_data;
`endif

  always_comb begin
    merged = '0;
    for (int unsigned b = 0; b < NumBytes; b++) begin
      merged[8*b +: 8] = be_q[b] ? data_q[8*b +: 8] : fill[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      data_q      <= '0;
      wr_data_q   <= '0;
      vd_q        <= '0;
      rd_addr_q   <= '0;
      be_q        <= '0;
      illegal_q   <= 1'b0;
      zero_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      we_q        <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      ill_pulse_q <= 1'b0;
    end else begin
      rd_en_q     <= 1'b0;
      done_q      <= 1'b0;
      ill_pulse_q <= 1'b0;
      if (vec_op_done && fifo_full && !pop) ovf_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (!fifo_empty) begin
            data_q    <= h_data;
            vd_q      <= h_vd;
            be_q      <= elem_to_byte_en(h_elem_en, h_vsew);
            illegal_q <= h_illegal;
            zero_q    <= (h_eff_vl == 6'd0);
            rd_addr_q <= h_vd;
`ifdef VEC_WB_AGNOSTIC_EN
            rd_en_q   <= 1'b0;
`else
            rd_en_q   <= !h_illegal && (h_eff_vl != 6'd0);
`endif
            state_q   <= StCheck;
          end
        end
        StCheck: begin
          if (illegal_q) begin
            done_q      <= 1'b1;
            ill_pulse_q <= 1'b1;
            state_q     <= StIdle;
          end else if (zero_q) begin
            done_q  <= 1'b1;
            state_q <= StIdle;
          end else begin
`ifdef VEC_WB_AGNOSTIC_EN
            // No old data needed, so the merge is folded into this cycle.
            wr_data_q <= merged;
            we_q      <= 1'b1;
            state_q   <= StWrite;
`else
            state_q   <= StMerge;
`endif
          end
        end
        StMerge: begin
          wr_data_q <= merged;
          we_q      <= 1'b1;
          state_q   <= StWrite;
        end
        StWrite: begin
          if (vrf.vrf_wr_ready) begin
            we_q    <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign vrf.vrf_rd_en   = rd_en_q;
  assign vrf.vrf_rd_addr = rd_addr_q;
  assign vrf.vrf_we      = we_q;
  assign vrf.vrf_wr_addr = vd_q;
  assign vrf.vrf_wr_data = wr_data_q;
  assign wb_ready        = !fifo_full;
  assign wb_done         = done_q;
  assign err_overflow    = ovf_q;
  assign err_illegal     = ill_pulse_q;

endmodule

// File: tb/tb_vec_writeback.sv
// Directed, table-driven bench for vec_writeback plus stall/overflow and reset-in-WRITE sequences.
module tb_vec_writeback;

`ifdef VEC_WB_AGNOSTIC_EN
  localparam logic [7:0] Fill   = 8'hFF;
  localparam int         Lat    = 3;
  localparam logic       ExpRd  = 1'b0;
`else
  localparam logic [7:0] Fill   = 8'hAA;
  localparam int         Lat    = 4;
  localparam logic       ExpRd  = 1'b1;
`endif

  typedef struct {
    logic [2:0]   vsew;
    logic [31:0]  vlen;
    logic         vm;
    logic [31:0]  v0;
    logic [255:0] result;
    logic [255:0] exp_data;
    int           exp_lat;   // 0: no write expected
    logic         exp_rd;
    logic         exp_ill;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         vec_op_done = 1'b0;
  logic [255:0] vec_exec_out = '0;
  logic [4:0]   vd_addr = '0;
  logic [2:0]   vsew = '0;
  logic [31:0]  vlen = '0;
  logic         vm = 1'b0;
  logic [31:0]  v0_mask = '0;
  logic         wb_ready, wb_done, err_overflow, err_illegal;

  int n_checks = 0;
  int n_errors = 0;

  vec_writeback_if #(.DATA_W(256), .REG_ADDR_W(5)) vrf_if ();

  vec_writeback dut (
    .clk          (clk),
    .reset        (reset),
    .vec_op_done  (vec_op_done),
    .vec_exec_out (vec_exec_out),
    .vd_addr      (vd_addr),
    .vsew         (vsew),
    .vlen         (vlen),
    .vm           (vm),
    .v0_mask      (v0_mask),
    .vrf          (vrf_if),
    .wb_ready     (wb_ready),
    .wb_done      (wb_done),
    .err_overflow (err_overflow),
    .err_illegal  (err_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] s, input logic [31:0] l, input logic m,
                              input logic [31:0] v0, input logic [255:0] r,
                              input logic [255:0] e, input int lat, input logic rd,
                              input logic ill);
    vec_t v;
    v.vsew = s; v.vlen = l; v.vm = m; v.v0 = v0; v.result = r;
    v.exp_data = e; v.exp_lat = lat; v.exp_rd = rd; v.exp_ill = ill;
    return v;
  endfunction

  task automatic drive(input vec_t v, input logic [4:0] vd);
    vec_exec_out = v.result; vd_addr = vd; vsew = v.vsew; vlen = v.vlen;
    vm = v.vm; v0_mask = v.v0; vec_op_done = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input logic [4:0] vd, input int idx);
    int lat = 0, done_n = 0, ill_n = 0;
    logic rd_seen = 1'b0;
    logic [4:0] rd_addr = '0, wr_addr = '0;
    logic [255:0] wr_data = '0;
    drive(v, vd);
    @(negedge clk);
    vec_op_done = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (vrf_if.vrf_rd_en) begin rd_seen = 1'b1; rd_addr = vrf_if.vrf_rd_addr; end
      if (vrf_if.vrf_we && lat == 0) begin
        lat = c; wr_data = vrf_if.vrf_wr_data; wr_addr = vrf_if.vrf_wr_addr;
      end
      done_n += int'(wb_done);
      ill_n  += int'(err_illegal);
      @(negedge clk);
    end
    check($sformatf("v%0d_latency", idx), 256'(lat), 256'(v.exp_lat));
    check($sformatf("v%0d_rd_en", idx), 256'(rd_seen), 256'(v.exp_rd));
    if (v.exp_rd) check($sformatf("v%0d_rd_addr", idx), 256'(rd_addr), 256'(vd));
    if (v.exp_lat != 0) begin
      check($sformatf("v%0d_wr_data", idx), wr_data, v.exp_data);
      check($sformatf("v%0d_wr_addr", idx), 256'(wr_addr), 256'(vd));
    end
    check($sformatf("v%0d_wb_done", idx), 256'(done_n), 256'(1));
    check($sformatf("v%0d_err_illegal", idx), 256'(ill_n), 256'(v.exp_ill));
  endtask

  task automatic wait_we(input string name);
    for (int c = 0; c < 10 && !vrf_if.vrf_we; c++) @(negedge clk);
    check(name, 256'(vrf_if.vrf_we), 256'(1));
  endtask

  vec_t vecs[7];
  logic [255:0] res11, old;

  initial begin
    res11 = {32{8'h11}};
    old   = {32{8'hAA}};
    vecs[0] = mk(3'd2, 32'd8, 1'b1, 32'h0, res11, res11, Lat, ExpRd, 1'b0);
    vecs[1] = mk(3'd0, 32'd5, 1'b0, 32'h15, res11,
                 {{26{Fill}}, Fill, 8'h11, Fill, 8'h11, Fill, 8'h11}, Lat, ExpRd, 1'b0);
    vecs[2] = mk(3'd2, 32'd0, 1'b1, 32'h0, res11, '0, 0, 1'b0, 1'b0);
    vecs[3] = mk(3'd3, 32'd100, 1'b1, 32'h0, {32{8'h5A}}, {32{8'h5A}}, Lat, ExpRd, 1'b0);
    vecs[4] = mk(3'd5, 32'd8, 1'b1, 32'h0, res11, '0, 0, 1'b0, 1'b1);
    vecs[5] = mk(3'd1, 32'd3, 1'b1, 32'h0, res11, {{26{Fill}}, {6{8'h11}}}, Lat, ExpRd, 1'b0);
    vecs[6] = mk(3'd2, 32'd8, 1'b0, 32'hFFFF_FF0A, res11,
                 {{16{Fill}}, {4{8'h11}}, {4{Fill}}, {4{8'h11}}, {4{Fill}}},
                 Lat, ExpRd, 1'b0);

    vrf_if.vrf_rd_data  = old;
    vrf_if.vrf_wr_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_we", 256'(vrf_if.vrf_we), 256'(0));
    check("reset_rd_en", 256'(vrf_if.vrf_rd_en), 256'(0));
    check("reset_wb_ready", 256'(wb_ready), 256'(1));
    check("reset_flags", 256'({wb_done, err_overflow, err_illegal}), 256'(0));
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], 5'(i + 3), i);
    check("no_overflow", 256'(err_overflow), 256'(0));

    // Write stall with three pushes arriving meanwhile.
    vrf_if.vrf_wr_ready = 1'b0;
    drive(vecs[0], 5'd9);
    @(negedge clk);
    vec_op_done = 1'b0;
    wait_we("stall_we_arrives");
    for (int c = 0; c < 5; c++) begin
      if (c < 3) drive(vecs[3], 5'd20);
      else vec_op_done = 1'b0;
      check($sformatf("stall%0d_we", c), 256'(vrf_if.vrf_we), 256'(1));
      check($sformatf("stall%0d_addr", c), 256'(vrf_if.vrf_wr_addr), 256'(9));
      check($sformatf("stall%0d_data", c), vrf_if.vrf_wr_data, res11);
      check($sformatf("stall%0d_done", c), 256'(wb_done), 256'(0));
      @(negedge clk);
    end
    vec_op_done = 1'b0;
    check("ovf_sticky_set", 256'(err_overflow), 256'(1));
    check("ovf_wb_ready_low", 256'(wb_ready), 256'(0));
    vrf_if.vrf_wr_ready = 1'b1;
    @(negedge clk);
    check("stall_done_pulse", 256'(wb_done), 256'(1));
    begin
      int dn = 0;
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        dn += int'(wb_done);
      end
      check("drain_done_count", 256'(dn), 256'(2));
    end
    check("drain_wb_ready", 256'(wb_ready), 256'(1));
    check("ovf_still_set", 256'(err_overflow), 256'(1));

    // Reset while a write is pending.
    vrf_if.vrf_wr_ready = 1'b0;
    drive(vecs[0], 5'd12);
    @(negedge clk);
    vec_op_done = 1'b0;
    wait_we("rst_we_arrives");
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_we", 256'(vrf_if.vrf_we), 256'(0));
    check("rst_mid_wb_ready", 256'(wb_ready), 256'(1));
    check("rst_mid_ovf", 256'(err_overflow), 256'(0));
    reset = 1'b1;
    vrf_if.vrf_wr_ready = 1'b1;
    begin
      int act = 0;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        act += int'(vrf_if.vrf_we) + int'(wb_done) + int'(vrf_if.vrf_rd_en);
      end
      check("rst_fifo_empty", 256'(act), 256'(0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
